mips_exc_ctrl: RTL and testbench

Exception/interrupt controller directly upstream of `single_cycle_cpu`. Takes the three asynchronous external exception sources (`expesrc0`, `expsrc1`, `expsrc2`), synchronises and edge-detects them, and latches them as pending. Pending sources are masked, priority-resolved and presented to the CPU as a single request with a handler vector. The block records the EPC on acknowledge and blocks nesting until the CPU returns with `eret`.

---
 rtl/mips_exc_pkg.sv | 37 +++
 rtl/mips_exc_ctrl_if.sv | 28 ++
 rtl/exc_sync_edge.sv | 36 +++
 rtl/mips_exc_ctrl.sv | 116 +++++++++++
 tb/tb_mips_exc_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_exc_pkg.sv
// mips_exc_pkg: shared types and constants for the MIPS exception controller.
//   - exc_state_e : controller FSM encoding (IDLE / REQ / SERVICE)
//   - CAUSE_*     : cause codes presented to the CPU, CAUSE_NONE = no winner
//   - CNT_W       : width of the optional per-source ack counters
//   - pick_winner : lowest-index active source wins
//   - cause_vector: handler address for a cause code
package mips_exc_pkg;

  localparam int NUM_SRC = 3;
  localparam int CNT_W   = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } exc_state_e;

  localparam logic [1:0] CAUSE_SRC0 = 2'd0;
  localparam logic [1:0] CAUSE_SRC1 = 2'd1;
  localparam logic [1:0] CAUSE_SRC2 = 2'd2;
  localparam logic [1:0] CAUSE_NONE = 2'd3;

  function automatic logic [1:0] pick_winner(input logic [NUM_SRC-1:0] act);
    if (act[0]) return CAUSE_SRC0;
    if (act[1]) return CAUSE_SRC1;
    if (act[2]) return CAUSE_SRC2;
    return CAUSE_NONE;
  endfunction

  // No winner points at the base itself rather than a fourth slot.
  function automatic logic [31:0] cause_vector(input logic [31:0] base,
                                               input logic [1:0]  c);
    if (c == CAUSE_NONE) return base;
    return base + {27'd0, c, 3'b000};
  endfunction

endpackage

// File: rtl/mips_exc_ctrl_if.sv
// mips_exc_ctrl_if: CPU <-> exception controller signal bundle.
//   master (CPU)  drives mask_we/mask_wdata, irq_ack/epc_in, eret
//   slave  (ctrl) drives irq, cause, irq_vector, epc, pending, mask
interface mips_exc_ctrl_if;
  import mips_exc_pkg::*;

  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               irq_ack;
  logic [31:0]        epc_in;
  logic               eret;
  logic               irq;
  logic [1:0]         cause;
  logic [31:0]        irq_vector;
  logic [31:0]        epc;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;

  modport master (
    output mask_we, mask_wdata, irq_ack, epc_in, eret,
    input  irq, cause, irq_vector, epc, pending, mask
  );

  modport slave (
    input  mask_we, mask_wdata, irq_ack, epc_in, eret,
    output irq, cause, irq_vector, epc, pending, mask
  );
endinterface

// File: rtl/exc_sync_edge.sv
// exc_sync_edge: SYNC_STAGES-deep synchroniser followed by a rising-edge
// detector for one asynchronous exception source.
//   clk, rst_n : clock, async active-low reset
//   async_in   : raw asynchronous source
//   rise_o     : one-cycle pulse on a synchronised 0->1 transition
// SYNC_STAGES must be at least 2.
module exc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/mips_exc_ctrl.sv
// mips_exc_ctrl: exception/interrupt controller in front of the CPU.
//   external_clk, reset : clock, async active-low reset
//   expesrc0..expsrc2   : async exception sources, 0 = highest priority
//   cpu (slave)         : mask write, irq/ack/epc, eret, status outputs
//   cnt_exc0..2         : saturating per-source ack counters, present only
//                         when MIPS_EXC_CNT_EN is defined
// Sources are synchronised and edge-detected into sticky pending bits; the
// masked lowest-index pending source is requested. One request is serviced
// at a time: after an ack the block stays in SERVICE until eret.
module mips_exc_ctrl
  import mips_exc_pkg::*;
#(
  parameter logic [31:0] VEC_BASE    = 32'h0000_0180,
  parameter int          SYNC_STAGES = 2
) (
  input  logic external_clk,
  input  logic reset,
  input  logic expesrc0,
  input  logic expsrc1,
  input  logic expsrc2,
  mips_exc_ctrl_if.slave cpu
`ifdef MIPS_EXC_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_exc0,
  output logic [CNT_W-1:0] cnt_exc1,
  output logic [CNT_W-1:0] cnt_exc2
`endif
);

  logic [NUM_SRC-1:0] src, rise;
  assign src = {expsrc2, expsrc1, expesrc0};

  exc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_SRC-1:0] (
    .clk      (external_clk),
    .rst_n    (reset),
    .async_in (src),
    .rise_o   (rise)
  );

  exc_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [1:0]         cause_q, cause_d;
  logic [31:0]        epc_q, epc_d;

  logic [NUM_SRC-1:0] active, clr;
  logic [1:0]         winner;
  logic               ack_ok;

  always_comb begin
    active = pending_q & mask_q;
    winner = pick_winner(active);
    // An ack in REQ with nothing active (mask just closed) is dropped.
    ack_ok = (state_q == ST_REQ) && cpu.irq_ack && (active != '0);
    clr    = ack_ok ? (3'b001 << winner) : 3'b000;
    // Set after clear: a fresh edge on the acked source stays pending.
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = cpu.mask_we ? cpu.mask_wdata : mask_q;
    cause_d   = ack_ok ? winner : cause_q;
    epc_d     = ack_ok ? cpu.epc_in : epc_q;

    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (active != '0) state_d = ST_REQ;
      ST_REQ:     if (ack_ok)             state_d = ST_SERVICE;
                  else if (active == '0)  state_d = ST_IDLE;
      ST_SERVICE: if (cpu.eret) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge external_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      mask_q    <= '1;
      cause_q   <= CAUSE_NONE;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
    end
  end

  // Live winner while requesting; the acked cause is held otherwise.
  assign cpu.irq        = (state_q == ST_REQ);
  assign cpu.cause      = (state_q == ST_REQ) ? winner : cause_q;
  assign cpu.irq_vector = cause_vector(VEC_BASE, cpu.cause);
  assign cpu.epc        = epc_q;
  assign cpu.pending    = pending_q;
  assign cpu.mask       = mask_q;

`ifdef MIPS_EXC_CNT_EN
  logic [NUM_SRC-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_SRC; i++)
      if (ack_ok && winner == 2'(i) && cnt_q[i] != {CNT_W{1'b1}})
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
  end

  always_ff @(posedge external_clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_exc0 = cnt_q[0];
  assign cnt_exc1 = cnt_q[1];
  assign cnt_exc2 = cnt_q[2];
`endif

endmodule

// File: tb/tb_mips_exc_ctrl.sv
// tb_mips_exc_ctrl: directed scenarios plus a randomized phase, every cycle
// compared against a behavioural model built from sample history and
// pending/request/service flags.
module tb_mips_exc_ctrl;

  localparam logic [31:0] VB = 32'h0000_0180;
  localparam int          S  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;

  mips_exc_ctrl_if cpu_if ();

`ifdef MIPS_EXC_CNT_EN
  logic [10:0] c0, c1, c2;
`endif

  mips_exc_ctrl #(.VEC_BASE(VB), .SYNC_STAGES(S)) dut (
    .external_clk (clk),
    .reset        (rst_n),
    .expesrc0     (s0),
    .expsrc1      (s1),
    .expsrc2      (s2),
    .cpu          (cpu_if)
`ifdef MIPS_EXC_CNT_EN
    ,
    .cnt_exc0     (c0),
    .cnt_exc1     (c1),
    .cnt_exc2     (c2)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  bit [2:0]    hist [S+2];   // hist[k] = source samples taken k edges ago
  bit [2:0]    m_pend, m_mask;
  bit          m_req, m_svc;
  int          m_cause;
  logic [31:0] m_epc;
  int          m_cnt [3];

  function automatic int win(input bit [2:0] a);
    for (int i = 0; i < 3; i++) if (a[i]) return i;
    return 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < S + 2; k++) hist[k] = 3'b000;
    m_pend = 3'b000; m_mask = 3'b111;
    m_req = 1'b0; m_svc = 1'b0;
    m_cause = 3; m_epc = 32'h0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge();
    bit [2:0] act, rises, clr;
    int w;
    bit acc;
    act = m_pend & m_mask;
    w   = win(act);
    acc = m_req && cpu_if.irq_ack && (act != 0);
    for (int k = S + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = {s2, s1, s0};
    // An input sampled S edges ago that was low one sample earlier lands now.
    rises = hist[S] & ~hist[S+1];
    clr = 3'b000;
    if (acc) clr[w] = 1'b1;
    m_pend = (m_pend & ~clr) | rises;
    if (cpu_if.mask_we) m_mask = cpu_if.mask_wdata;
    if (m_req) begin
      if (acc) begin m_req = 1'b0; m_svc = 1'b1; end
      else if (act == 0) m_req = 1'b0;
    end else if (m_svc) begin
      if (cpu_if.eret) m_svc = 1'b0;
    end else if (act != 0) m_req = 1'b1;
    if (acc) begin
      m_epc = cpu_if.epc_in;
      m_cause = w;
      if (m_cnt[w] < 2047) m_cnt[w]++;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int ec;
    ec = m_req ? win(m_pend & m_mask) : m_cause;
    chk({tag, ".irq"},     32'(cpu_if.irq), 32'(m_req));
    chk({tag, ".cause"},   32'(cpu_if.cause), 32'(ec));
    chk({tag, ".vector"},  cpu_if.irq_vector, (ec == 3) ? VB : VB + 32'(ec * 8));
    chk({tag, ".epc"},     cpu_if.epc, m_epc);
    chk({tag, ".pending"}, 32'(cpu_if.pending), 32'(m_pend));
    chk({tag, ".mask"},    32'(cpu_if.mask), 32'(m_mask));
`ifdef MIPS_EXC_CNT_EN
    chk({tag, ".cnt0"}, 32'(c0), 32'(m_cnt[0]));
    chk({tag, ".cnt1"}, 32'(c1), 32'(m_cnt[1]));
    chk({tag, ".cnt2"}, 32'(c2), 32'(m_cnt[2]));
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic clr_inputs();
    s0 = 0; s1 = 0; s2 = 0;
    cpu_if.mask_we = 0; cpu_if.mask_wdata = 3'b000;
    cpu_if.irq_ack = 0; cpu_if.epc_in = 32'h0; cpu_if.eret = 0;
  endtask

  // Asserts reset between edges and checks outputs before the next edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    clr_inputs();
    model_reset();
    #1;
    chk({tag, ".irq0"},   32'(cpu_if.irq), 32'h0);
    chk({tag, ".cause3"}, 32'(cpu_if.cause), 32'h3);
    chk({tag, ".vec"},    cpu_if.irq_vector, 32'h180);
    chk({tag, ".mask7"},  32'(cpu_if.mask), 32'h7);
    chk({tag, ".pend0"},  32'(cpu_if.pending), 32'h0);
    chk({tag, ".epc0"},   cpu_if.epc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef MIPS_EXC_CNT_EN
  task automatic serve0();
    int n;
    s0 = 1; tick("cnt.src");
    s0 = 0;
    n = 0;
    while (!cpu_if.irq && n < 10) begin tick("cnt.wait"); n++; end
    chk("cnt.irq_wait", 32'(cpu_if.irq), 32'h1);
    cpu_if.irq_ack = 1; tick("cnt.ack");
    cpu_if.irq_ack = 0; cpu_if.eret = 1; tick("cnt.eret");
    cpu_if.eret = 0;
  endtask
`endif

  initial begin
    clr_inputs();
    model_reset();
    // Reset then idle
    #1 rst_n = 1'b0;
    #1;
    chk("rst.irq", 32'(cpu_if.irq), 32'h0);
    chk("rst.cause", 32'(cpu_if.cause), 32'h3);
    chk("rst.vec", cpu_if.irq_vector, 32'h180);
    chk("rst.mask", 32'(cpu_if.mask), 32'h7);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick("idle");
      chk("idle.irq", 32'(cpu_if.irq), 32'h0);
    end

    // Single source 1
    s1 = 1; tick("single.e0");
    s1 = 0; tick("single.e1");
    tick("single.e2");
    chk("single.pend", 32'(cpu_if.pending), 32'h2);
    chk("single.noirq", 32'(cpu_if.irq), 32'h0);
    tick("single.e3");
    chk("single.irq", 32'(cpu_if.irq), 32'h1);
    chk("single.cause", 32'(cpu_if.cause), 32'h1);
    chk("single.vec", cpu_if.irq_vector, 32'h188);
    cpu_if.irq_ack = 1; cpu_if.epc_in = 32'h0040_0020; tick("single.ack");
    chk("single.epc", cpu_if.epc, 32'h0040_0020);
    chk("single.pclr", 32'(cpu_if.pending), 32'h0);
    chk("single.irqlo", 32'(cpu_if.irq), 32'h0);
    cpu_if.irq_ack = 0; cpu_if.eret = 1; tick("single.eret");
    cpu_if.eret = 0; tick("single.idle");

    // Priority and nesting
    s0 = 1; s2 = 1; tick("prio.e0");
    s0 = 0; s2 = 0; tick("prio.e1");
    tick("prio.e2");
    chk("prio.pend", 32'(cpu_if.pending), 32'h5);
    tick("prio.e3");
    chk("prio.cause0", 32'(cpu_if.cause), 32'h0);
    cpu_if.irq_ack = 1; cpu_if.epc_in = 32'h0000_1000; tick("prio.ack0");
    cpu_if.irq_ack = 0;
    chk("prio.svc_cause", 32'(cpu_if.cause), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick("prio.svc");
      chk("prio.svc_irq", 32'(cpu_if.irq), 32'h0);
    end
    cpu_if.eret = 1; tick("prio.eret");
    cpu_if.eret = 0; tick("prio.reeval");
    chk("prio.irq2", 32'(cpu_if.irq), 32'h1);
    chk("prio.cause2", 32'(cpu_if.cause), 32'h2);
    chk("prio.vec2", cpu_if.irq_vector, 32'h190);
    cpu_if.irq_ack = 1; cpu_if.epc_in = 32'h0000_2000; tick("prio.ack2");
    cpu_if.irq_ack = 0; cpu_if.eret = 1; tick("prio.eret2");
    cpu_if.eret = 0; tick("prio.done");

    // Masking
    cpu_if.mask_we = 1; cpu_if.mask_wdata = 3'b011; tick("mask.wr");
    cpu_if.mask_we = 0; s2 = 1; tick("mask.e0");
    s2 = 0; tick("mask.e1");
    tick("mask.e2");
    tick("mask.e3");
    chk("mask.pend", 32'(cpu_if.pending), 32'h4);
    chk("mask.noirq", 32'(cpu_if.irq), 32'h0);
    cpu_if.mask_we = 1; cpu_if.mask_wdata = 3'b111; tick("mask.open");
    cpu_if.mask_we = 0; tick("mask.req");
    chk("mask.irq", 32'(cpu_if.irq), 32'h1);
    cpu_if.mask_we = 1; cpu_if.mask_wdata = 3'b000; tick("mask.close");
    cpu_if.mask_we = 0; tick("mask.drop");
    chk("mask.irqlo", 32'(cpu_if.irq), 32'h0);
    tick("mask.idle");
    do_reset("rst1");

    // Boundary: new edge on the acked source keeps it pending
    s0 = 1; tick("bnd.e0");
    s0 = 0; tick("bnd.e1");
    s0 = 1; tick("bnd.e2");
    s0 = 0; tick("bnd.e3");
    chk("bnd.irq", 32'(cpu_if.irq), 32'h1);
    cpu_if.irq_ack = 1; cpu_if.epc_in = 32'hBFC0_0000; tick("bnd.ack");
    cpu_if.irq_ack = 0;
    chk("bnd.pend0", 32'(cpu_if.pending), 32'h1);
    tick("bnd.svc");
    do_reset("rst_svc");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      s0 = ($urandom % 8) == 0;
      s1 = ($urandom % 8) == 0;
      s2 = ($urandom % 8) == 0;
      cpu_if.irq_ack = ($urandom % 3) == 0;
      cpu_if.epc_in = $urandom;
      cpu_if.eret = ($urandom % 4) == 0;
      cpu_if.mask_we = ($urandom % 16) == 0;
      cpu_if.mask_wdata = 3'($urandom);
      tick("rand");
    end
    do_reset("rst2");

`ifdef MIPS_EXC_CNT_EN
    for (int i = 0; i < 3; i++) serve0();
    chk("cnt.three", 32'(c0), 32'd3);
    for (int i = 3; i < 2050; i++) serve0();
    chk("cnt.sat", 32'(c0), 32'h7FF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
